// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sweep checker: op encodings, the order in
// which the sweep visits the ops, and the checker FSM state encodings.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int N_OPS = 5;

    // Sweep order, entry 0 in the least significant bits.
    localparam logic [14:0] OP_ORDER = {OP_SLT, OP_SUB, OP_ADD, OP_OR, OP_AND};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Op select for a given position in the sweep order.
    function automatic logic [2:0] op_at(input logic [2:0] idx);
        logic [2:0] op;
        case (idx)
            3'd0:    op = OP_ORDER[2:0];
            3'd1:    op = OP_ORDER[5:3];
            3'd2:    op = OP_ORDER[8:6];
            3'd3:    op = OP_ORDER[11:9];
            3'd4:    op = OP_ORDER[14:12];
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the datapath ALU used by the sweep checker.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  sel,
    output logic [31:0] exp_out,
    output logic        exp_zero
);

    // Golden result for the selected op; unknown selects produce zero.
    always_comb begin
        exp_out = 32'd0;
        case (sel)
            OP_AND:  exp_out = a & b;
            OP_OR:   exp_out = a | b;
            OP_ADD:  exp_out = a + b;
            OP_SUB:  exp_out = a - b;
            OP_SLT:  exp_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: exp_out = 32'd0;
        endcase
        exp_zero = (exp_out == 32'd0);
    end

endmodule

// File: rtl/alu_sweep_checker.sv
// Sweeps every op x A x B vector through the external ALU, compares its
// result and zero flag against alu_ref_model and reports done/pass plus
// saturating error and vector counts.
// Optional: define ALU_CHK_FIRSTFAIL_EN to capture the first failing vector.
module alu_sweep_checker
    import alu_pkg::*;
#(
    parameter int N_A    = 10,
    parameter int N_B    = 10,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_sel,
    input  logic [31:0]      alu_out,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
`ifdef ALU_CHK_FIRSTFAIL_EN
    output logic             ff_valid,
    output logic [2:0]       ff_sel,
    output logic [31:0]      ff_a,
    output logic [31:0]      ff_b,
    output logic [31:0]      ff_got,
    output logic [31:0]      ff_exp,
`endif
    output logic [15:0]      vec_count
);

    state_t r_state;
    state_t w_next_state;

    logic [2:0]       r_op_idx;
    logic [15:0]      r_a_idx;
    logic [15:0]      r_b_idx;
    logic [3:0]       r_settle;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [2:0]       r_alu_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [15:0]      r_vec;

    logic [31:0]      w_exp_out;
    logic             w_exp_zero;
    logic             w_mismatch;
    logic             w_last_b;
    logic             w_last_a;
    logic             w_last_vec;
    logic [ERR_W-1:0] w_err_next;
    logic             w_accept;
    logic             w_apply;
    logic             w_wait;
    logic             w_check;

    alu_ref_model u_ref (
        .a        (r_alu_a),
        .b        (r_alu_b),
        .sel      (r_alu_sel),
        .exp_out  (w_exp_out),
        .exp_zero (w_exp_zero)
    );

    // Sweep position and comparison results for the vector under check.
    always_comb begin
        w_last_b   = (r_b_idx == 16'(N_B - 1));
        w_last_a   = (r_a_idx == 16'(N_A - 1));
        w_last_vec = w_last_b && w_last_a && (r_op_idx == 3'(N_OPS - 1));
        w_mismatch = (alu_out != w_exp_out) || (alu_zero != w_exp_zero);
        if (w_mismatch && (r_err != {ERR_W{1'b1}})) begin
            w_err_next = r_err + ERR_W'(1);
        end else begin
            w_err_next = r_err;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = start ? ST_APPLY : ST_IDLE;
            ST_APPLY: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = (r_settle <= 4'd1) ? ST_CHECK : ST_WAIT;
            ST_CHECK: w_next_state = w_last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:  w_next_state = start ? ST_APPLY : ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // FSM output decode into datapath strobes.
    always_comb begin
        w_accept = 1'b0;
        w_apply  = 1'b0;
        w_wait   = 1'b0;
        w_check  = 1'b0;
        case (r_state)
            ST_IDLE:  w_accept = start;
            ST_APPLY: w_apply  = 1'b1;
            ST_WAIT:  w_wait   = 1'b1;
            ST_CHECK: w_check  = 1'b1;
            ST_DONE:  w_accept = start;
            default:  w_accept = 1'b0;
        endcase
    end

    // Sweep indices, settle timer and registered ALU operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_idx  <= 3'd0;
            r_a_idx   <= 16'd0;
            r_b_idx   <= 16'd0;
            r_settle  <= 4'd0;
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_sel <= 3'd0;
        end else if (w_accept) begin
            r_op_idx <= 3'd0;
            r_a_idx  <= 16'd0;
            r_b_idx  <= 16'd0;
        end else if (w_apply) begin
            r_alu_a   <= 32'(r_a_idx);
            r_alu_b   <= 32'(r_b_idx);
            r_alu_sel <= op_at(r_op_idx);
            r_settle  <= 4'(SETTLE);
        end else if (w_wait) begin
            r_settle <= r_settle - 4'd1;
        end else if (w_check) begin
            if (w_last_b) begin
                r_b_idx <= 16'd0;
                if (w_last_a) begin
                    r_a_idx  <= 16'd0;
                    r_op_idx <= r_op_idx + 3'd1;
                end else begin
                    r_a_idx <= r_a_idx + 16'd1;
                end
            end else begin
                r_b_idx <= r_b_idx + 16'd1;
            end
        end
    end

    // Status flags and counters; pass is settled together with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= {ERR_W{1'b0}};
            r_vec  <= 16'd0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= {ERR_W{1'b0}};
            r_vec  <= 16'd0;
        end else if (w_check) begin
            r_vec <= r_vec + 16'd1;
            r_err <= w_err_next;
            if (w_last_vec) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_err_next == {ERR_W{1'b0}});
            end
        end
    end

`ifdef ALU_CHK_FIRSTFAIL_EN
    logic        r_ff_valid;
    logic [2:0]  r_ff_sel;
    logic [31:0] r_ff_a;
    logic [31:0] r_ff_b;
    logic [31:0] r_ff_got;
    logic [31:0] r_ff_exp;

    // Latch the first mismatching vector of the current sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ff_valid <= 1'b0;
            r_ff_sel   <= 3'd0;
            r_ff_a     <= 32'd0;
            r_ff_b     <= 32'd0;
            r_ff_got   <= 32'd0;
            r_ff_exp   <= 32'd0;
        end else if (w_accept) begin
            r_ff_valid <= 1'b0;
            r_ff_sel   <= 3'd0;
            r_ff_a     <= 32'd0;
            r_ff_b     <= 32'd0;
            r_ff_got   <= 32'd0;
            r_ff_exp   <= 32'd0;
        end else if (w_check && w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_sel   <= r_alu_sel;
            r_ff_a     <= r_alu_a;
            r_ff_b     <= r_alu_b;
            r_ff_got   <= alu_out;
            r_ff_exp   <= w_exp_out;
        end
    end

    assign ff_valid = r_ff_valid;
    assign ff_sel   = r_ff_sel;
    assign ff_a     = r_ff_a;
    assign ff_b     = r_ff_b;
    assign ff_got   = r_ff_got;
    assign ff_exp   = r_ff_exp;
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign vec_count = r_vec;

endmodule
